oam_dma: RTL

Sprite OAM DMA engine on the CPU system bus, filling the empty DMA slot in the system top. It detects a CPU write to $4014, halts the CPU, and arbitrates for the bus through the existing memory arbiter as a second requester. It then copies 256 bytes from CPU page $XX00–$XXFF into the PPU OAM data register $2004 as alternating read/write cycles. Its outputs feed the system bus (RAM/PPU) and the CPU ready line.

---
 rtl/nes_pkg.sv | 22 ++
 rtl/oam_dma.sv | 113 +++++++++++
 2 files changed

// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_pkg
// Brief    : Shared constants and the sprite DMA state enum.
// Revision : 1.0
// ============================================================================
package nes_pkg;

    localparam logic [15:0] NES_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] NES_OAM_ADDR  = 16'h2004;
    localparam int          NES_DMA_LEN   = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Brief    : Sprite OAM DMA; copies one CPU page into $2004 while the CPU is halted.
// Revision : 1.0
// ============================================================================
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = NES_TRIG_ADDR,
    parameter logic [15:0] OAM_ADDR  = NES_OAM_ADDR,
    parameter int          LEN       = NES_DMA_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wr,
    input  logic        grant,
    output logic        req,
    output logic        halt,
    output logic        busy,
    output logic        dma_en,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata,
    input  logic [7:0]  dma_rdata
);

    localparam logic [7:0] C_LAST_IDX = 8'(LEN - 1);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_buf_q, data_buf_d;
    logic       parity_q, parity_d;

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_buf_d = data_buf_q;
        parity_d   = ~parity_q;
        // Every non-idle step only advances while the arbiter grants the bus.
        case (state_q)
            IDLE: begin
                if (cpu_wr && (cpu_addr == TRIG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT: begin
                if (grant) begin
                    state_d = parity_q ? ALIGN : READ;
                end
            end
            ALIGN: begin
                if (grant) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (grant) begin
                    data_buf_d = dma_rdata;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (grant) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == C_LAST_IDX) ? IDLE : READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            page_q     <= 8'd0;
            idx_q      <= 8'd0;
            data_buf_q <= 8'd0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            data_buf_q <= data_buf_d;
            parity_q   <= parity_d;
        end
    end

    logic in_idle;
    logic in_read;
    logic in_write;

    assign in_idle  = (state_q == IDLE);
    assign in_read  = (state_q == READ);
    assign in_write = (state_q == WRITE);

    assign req       = ~in_idle;
    assign halt      = ~in_idle;
    assign busy      = ~in_idle;
    assign dma_en    = grant & (in_read | in_write);
    assign dma_rw    = ~in_write;
    assign dma_addr  = in_read  ? {page_q, idx_q} :
                       in_write ? OAM_ADDR        : 16'h0000;
    assign dma_wdata = in_write ? data_buf_q : 8'h00;

endmodule
`default_nettype wire
